// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: feeds the north (weights) and west (activations) edges
// of an output-stationary PE grid. Each accepted K-beat is diagonally skewed
// (lane i delayed i extra cycles), then the grid is zero-flushed until the
// far-corner PE has consumed its last operand. Drives grid-wide array_en and
// clear_acc, and pulses done at the end of the job.
// Optional build macro SYSTOLIC_FEEDER_PERF_EN adds stall_cnt and job_cycles.

// One skew lane: DEPTH-deep shift chain followed by the output register,
// giving a total delay of DEPTH+1 shifts from the input.
module systolic_edge_feeder_skew_lane #(
    parameter int DW    = 16,
    parameter int DEPTH = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          shift_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] q_q;

    if (DEPTH == 0) begin : g_direct
        // Output register only: lane 0 appears one shift after acceptance.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_q <= '0;
            end else if (clear_i) begin
                q_q <= '0;
            end else if (shift_i) begin
                q_q <= d_i;
            end
        end
    end else begin : g_chain
        logic [DW-1:0] chain_q [DEPTH];

        // Shift chain plus output register; everything holds while the grid stalls.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int m = 0; m < DEPTH; m++) chain_q[m] <= '0;
                q_q <= '0;
            end else if (clear_i) begin
                for (int m = 0; m < DEPTH; m++) chain_q[m] <= '0;
                q_q <= '0;
            end else if (shift_i) begin
                chain_q[0] <= d_i;
                for (int m = 1; m < DEPTH; m++) chain_q[m] <= chain_q[m-1];
                q_q <= chain_q[DEPTH-1];
            end
        end
    end

    assign q_o = q_q;

endmodule

module systolic_edge_feeder #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [K_WIDTH-1:0]         k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [COLS*DATA_WIDTH-1:0] in_a,
    input  logic [ROWS*DATA_WIDTH-1:0] in_b,
    output logic [COLS*DATA_WIDTH-1:0] north_a,
    output logic [ROWS*DATA_WIDTH-1:0] west_b,
    output logic                       array_en,
    output logic                       clear_acc,
    output logic                       busy,
    output logic                       done
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                job_cycles
`endif
);

    localparam int DW         = DATA_WIDTH;
    // Far-corner PE sees its last operand ROWS+COLS-1 shifts after the last beat.
    localparam int FLUSH_LAST = ROWS + COLS - 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [K_WIDTH-1:0]   k_len_q, k_len_d;
    logic [K_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [K_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;

    logic                 accept_s;
    logic                 shift_s;
    logic                 clear_edges_s;
    logic [COLS*DW-1:0]   feed_a_s;
    logic [ROWS*DW-1:0]   feed_b_s;

    // State, latched job length and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state and control decode; array_en follows acceptance in STREAM so
    // a missing beat freezes the whole grid instead of injecting a bubble.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        in_ready    = 1'b0;
        array_en    = 1'b0;
        clear_acc   = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    k_len_d     = k_len;
                    beat_cnt_d  = '0;
                    flush_cnt_d = '0;
                    state_d     = S_CLEAR;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_CLEAR: begin
                clear_acc = 1'b1;
                array_en  = 1'b1;
                if (k_len_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    array_en   = 1'b1;
                    beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
                    if (beat_cnt_q == (k_len_q - K_WIDTH'(1))) begin
                        flush_cnt_d = '0;
                        state_d     = S_FLUSH;
                    end else begin
                        state_d     = S_STREAM;
                    end
                end else begin
                    array_en = 1'b0;
                end
            end
            S_FLUSH: begin
                array_en = 1'b1;
                if (flush_cnt_q == K_WIDTH'(FLUSH_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + K_WIDTH'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign accept_s      = (state_q == S_STREAM) && in_valid;
    assign shift_s       = accept_s || (state_q == S_FLUSH);
    assign clear_edges_s = (state_q == S_CLEAR);
    assign feed_a_s      = (state_q == S_STREAM) ? in_a : '0;
    assign feed_b_s      = (state_q == S_STREAM) ? in_b : '0;

    for (genvar j = 0; j < COLS; j++) begin : g_north
        systolic_edge_feeder_skew_lane #(.DW(DW), .DEPTH(j)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (clear_edges_s),
            .shift_i (shift_s),
            .d_i     (feed_a_s[j*DW +: DW]),
            .q_o     (north_a[j*DW +: DW])
        );
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_west
        systolic_edge_feeder_skew_lane #(.DW(DW), .DEPTH(i)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (clear_edges_s),
            .shift_i (shift_s),
            .d_i     (feed_b_s[i*DW +: DW]),
            .q_o     (west_b[i*DW +: DW])
        );
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] job_cycles_q;

    // Saturating count of STREAM cycles without a beat, restarted per job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_cnt_q <= 32'd0;
        end else if ((state_q == S_STREAM) && !in_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // Job length: 1 in CLEAR, +1 per cycle, so DONE shows CLEAR..DONE inclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_cycles_q <= 32'd0;
        end else if ((state_q == S_IDLE) && start) begin
            job_cycles_q <= 32'd1;
        end else if ((state_q == S_CLEAR) || (state_q == S_STREAM) || (state_q == S_FLUSH)) begin
            if (job_cycles_q != 32'hFFFF_FFFF) begin
                job_cycles_q <= job_cycles_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign job_cycles = job_cycles_q;
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Self-checking bench for systolic_edge_feeder (4x4). Edge outputs are
// predicted from the list of operand pushes seen by the grid: after n shifts,
// lane j shows push n-1-j. A behavioural PE grid closes the loop end-to-end.
module tb_systolic_edge_feeder;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 16;
    localparam int KW   = 16;
    localparam int NFL  = ROWS + COLS - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [KW-1:0]      k_len;
    logic               in_valid;
    logic               in_ready;
    logic [COLS*DW-1:0] in_a;
    logic [ROWS*DW-1:0] in_b;
    logic [COLS*DW-1:0] north_a;
    logic [ROWS*DW-1:0] west_b;
    logic               array_en;
    logic               clear_acc;
    logic               busy;
    logic               done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [31:0]        stall_cnt;
    logic [31:0]        job_cycles;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [COLS*DW-1:0] pa[$];
    logic [ROWS*DW-1:0] pb[$];

    int pe_a   [ROWS][COLS];
    int pe_b   [ROWS][COLS];
    int pe_acc [ROWS][COLS];

    always #5 clk = ~clk;

    systolic_edge_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .north_a   (north_a),
        .west_b    (west_b),
        .array_en  (array_en),
        .clear_acc (clear_acc),
        .busy      (busy),
        .done      (done)
`ifdef SYSTOLIC_FEEDER_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .job_cycles(job_cycles)
`endif
    );

    function automatic int a_in(int i, int j);
        if (i == 0) return int'(north_a[j*DW +: DW]);
        else        return pe_a[i-1][j];
    endfunction

    function automatic int b_in(int i, int j);
        if (j == 0) return int'(west_b[i*DW +: DW]);
        else        return pe_b[i][j-1];
    endfunction

    // Behavioural output-stationary grid: a flows down, b flows right.
    always @(posedge clk) begin
        if (array_en) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    pe_a[i][j]   <= a_in(i, j);
                    pe_b[i][j]   <= b_in(i, j);
                    pe_acc[i][j] <= clear_acc ? 0 : pe_acc[i][j] + a_in(i, j) * b_in(i, j);
                end
            end
        end
    end

    function automatic logic [COLS*DW-1:0] exp_north();
        logic [COLS*DW-1:0] r = '0;
        for (int j = 0; j < COLS; j++) begin
            int idx = pa.size() - 1 - j;
            if (idx >= 0) r[j*DW +: DW] = pa[idx][j*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic [ROWS*DW-1:0] exp_west();
        logic [ROWS*DW-1:0] r = '0;
        for (int i = 0; i < ROWS; i++) begin
            int idx = pb.size() - 1 - i;
            if (idx >= 0) r[i*DW +: DW] = pb[idx][i*DW +: DW];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string ph, input logic e_ready, input logic e_en,
                              input logic e_clr, input logic e_busy, input logic e_done);
        check({ph, "_in_ready"},  in_ready,  e_ready);
        check({ph, "_array_en"},  array_en,  e_en);
        check({ph, "_clear_acc"}, clear_acc, e_clr);
        check({ph, "_busy"},      busy,      e_busy);
        check({ph, "_done"},      done,      e_done);
    endtask

    task automatic check_edges(input string ph);
        check({ph, "_north_a"}, north_a, exp_north());
        check({ph, "_west_b"},  west_b,  exp_west());
    endtask

    task automatic rand_data();
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
    endtask

    task automatic idle_cycles(input int n, input bit vnoise);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = vnoise ? 1'b1 : 1'b0;
            rand_data();
            @(negedge clk);
            check_ctrl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("idle_north_a", north_a, 64'd0);
            check("idle_west_b",  west_b,  64'd0);
        end
    endtask

    // vmode: 0 = always valid, 1 = vpat bit per STREAM cycle, 2 = random.
    task automatic run_job(input int k, input int vmode, input logic [31:0] vpat,
                           input bit noise, input int abort_at, input bit eye);
        int  acc_n  = 0;
        int  sc     = 0;
        int  stalls = 0;
        bit  v;
        pa.delete();
        pb.delete();

        @(posedge clk); #1;
        start    = 1'b1;
        k_len    = KW'(k);
        in_valid = noise;
        rand_data();
        @(negedge clk);
        check_ctrl("start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(posedge clk); #1;
        start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        k_len    = noise ? KW'($urandom) : k_len;
        in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        check_ctrl("clear", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_edges("clear");

        while (acc_n < k) begin
            @(posedge clk); #1;
            if (vmode == 0)       v = 1'b1;
            else if (vmode == 1)  v = (sc < 32) ? vpat[sc] : 1'b1;
            else                  v = (sc > 4*k + 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid = v;
            if (eye) begin
                in_a = '0;
                in_b = '0;
                for (int j = 0; j < COLS; j++) in_a[j*DW +: DW] = (j == acc_n) ? 16'd1 : 16'd0;
                for (int i = 0; i < ROWS; i++) in_b[i*DW +: DW] = DW'(i*4 + acc_n + 1);
            end else begin
                rand_data();
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            k_len = noise ? KW'($urandom) : k_len;
            @(negedge clk);
            check_ctrl("stream", 1'b1, v, 1'b0, 1'b1, 1'b0);
            check_edges("stream");
            if (v) begin
                pa.push_back(in_a);
                pb.push_back(in_b);
                acc_n++;
            end else begin
                stalls++;
            end
            sc++;
        end

        if (k > 0) begin
            for (int f = 0; f < NFL; f++) begin
                @(posedge clk); #1;
                in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                rand_data();
                if (f == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_ctrl("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    check("abort_north_a", north_a, 64'd0);
                    check("abort_west_b",  west_b,  64'd0);
                    @(posedge clk); #1;
                    rst_n    = 1'b1;
                    start    = 1'b0;
                    in_valid = 1'b0;
                    idle_cycles(NFL + 2, 1'b0);
                    return;
                end
                @(negedge clk);
                check_ctrl("flush", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
                check_edges("flush");
                pa.push_back('0);
                pb.push_back('0);
            end
        end

        @(posedge clk); #1;
        in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        check_ctrl("done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("done_north_a", north_a, 64'd0);
        check("done_west_b",  west_b,  64'd0);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        check("stall_cnt",  stall_cnt,  32'(stalls));
        check("job_cycles", job_cycles, 32'(1 + sc + ((k > 0) ? NFL : 0) + 1));
`endif

        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = noise;
        @(negedge clk);
        check_ctrl("post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_north_a", north_a, 64'd0);
        check("post_west_b",  west_b,  64'd0);
    endtask

    initial begin
        int exp_c;
        rst_n    = 1'b0;
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_north_a", north_a, 64'd0);
        check("reset_west_b",  west_b,  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // in_valid in IDLE is ignored.
        idle_cycles(3, 1'b1);

        // T1: k=3, no stalls; done 12 cycles after start.
        run_job(3, 0, 32'd0, 1'b0, -1, 1'b0);

        // T2: k=3, two stall cycles after beat 1.
        run_job(3, 1, 32'b10011, 1'b0, -1, 1'b0);

        // T3: k=0 goes CLEAR then DONE.
        run_job(0, 0, 32'd0, 1'b0, -1, 1'b0);

        // T4: reset during third FLUSH cycle, then a fresh k=1 job.
        run_job(5, 0, 32'd0, 1'b0, 2, 1'b0);
        run_job(1, 0, 32'd0, 1'b0, -1, 1'b0);

        // T5: stray start / k_len / in_valid outside their windows.
        idle_cycles(2, 1'b1);
        run_job(3, 0, 32'd0, 1'b1, -1, 1'b0);

        // Randomized jobs with random stalls and noise.
        for (int r = 0; r < 20; r++) begin
            run_job($urandom_range(1, 9), 2, 32'd0, 1'b1, -1, 1'b0);
            idle_cycles($urandom_range(0, 2), 1'b1);
        end

        // T6: end-to-end, A = identity, B = ramp, k=4; C[i][j] = sum_k b_k[i]*a_k[j].
        run_job(4, 0, 32'd0, 1'b0, -1, 1'b1);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                exp_c = 0;
                for (int n = 0; n < 4; n++) begin
                    exp_c += ((j == n) ? 1 : 0) * (i*4 + n + 1);
                end
                check($sformatf("pe_result_%0d_%0d", i, j), 128'(pe_acc[i][j]), 128'(exp_c));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
